// File: rtl/rv32_fetch_queue.sv
// RV32I IF stage: owns the fetch PC and buffers {instr, pc} pairs ahead of decode.
// Optional same-cycle bypass on an empty queue is enabled by defining RV_FQ_BYPASS_EN.
module rv32_fetch_queue #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    output logic                       imem_req_o,
    output logic [XLEN-1:0]            imem_addr_o,
    input  logic [31:0]                imem_rdata_i,
    input  logic                       dec_ready_i,
    output logic                       dec_valid_o,
    output logic [31:0]                dec_instr_o,
    output logic [XLEN-1:0]            dec_pc_o,
    output logic [XLEN-1:0]            dec_pc4_o,
    output logic [$clog2(DEPTH):0]     fq_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] fetch_pc;
    logic [31:0]     instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];

    logic not_empty;
    logic full;
    logic head_valid;
    logic bypass;
    logic pop;
    logic push;
    logic write;

    assign not_empty  = (count != '0);
    assign full       = (count == CW'(DEPTH));
    assign head_valid = not_empty & ~redirect_i;

`ifdef RV_FQ_BYPASS_EN
    assign bypass = ~not_empty & ~redirect_i & dec_ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign pop   = head_valid & dec_ready_i;
    assign push  = ~redirect_i & (~full | pop);
    // A bypassed word goes straight to decode and never occupies a slot.
    assign write = push & ~bypass;

    assign imem_req_o  = push;
    assign imem_addr_o = fetch_pc;
    assign fq_count_o  = count;

    always_comb begin
        dec_valid_o = 1'b0;
        dec_instr_o = NOP;
        dec_pc_o    = '0;
        if (bypass) begin
            dec_valid_o = 1'b1;
            dec_instr_o = imem_rdata_i;
            dec_pc_o    = fetch_pc;
        end else if (head_valid) begin
            dec_valid_o = 1'b1;
            dec_instr_o = instr_q[rd_ptr];
            dec_pc_o    = pc_q[rd_ptr];
        end
    end

    assign dec_pc4_o = dec_pc_o + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) fetch_pc <= fetch_pc + XLEN'(4);
            if (write) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({write, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (write) begin
            instr_q[wr_ptr] <= imem_rdata_i;
            pc_q[wr_ptr]    <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_rv32_fetch_queue.sv
// Randomised bench for rv32_fetch_queue against a queue-based reference model.
module tb_rv32_fetch_queue;
    localparam int DEPTH = 4;
`ifdef RV_FQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        dec_ready_i;
    logic        dec_valid_o;
    logic [31:0] dec_instr_o;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_pc4_o;
    logic [2:0]  fq_count_o;

    rv32_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
        .dec_ready_i(dec_ready_i), .dec_valid_o(dec_valid_o), .dec_instr_o(dec_instr_o),
        .dec_pc_o(dec_pc_o), .dec_pc4_o(dec_pc4_o), .fq_count_o(fq_count_o)
    );

    always #5 clk = ~clk;
    assign imem_rdata_i = 32'hA000_0000 | imem_addr_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] q_pc[$];   // PCs waiting in the model queue, oldest first
    logic [31:0] m_pc;      // model fetch PC

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    // Drive one cycle of inputs (caller is just after a negedge), check, advance model.
    task automatic step(input bit rd, input bit redir, input logic [31:0] rpc);
        int    sz;
        bit    byp, ev, pop, req;
        logic [31:0] epc;
        dec_ready_i   = rd;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        #1;
        sz  = q_pc.size();
        byp = BYP && sz == 0 && !redir && rd;
        ev  = !redir && (sz > 0 || byp);
        epc = byp ? m_pc : (ev ? q_pc[0] : 32'h0);
        pop = ev && rd && !byp;
        req = !redir && (sz < DEPTH || pop);
        chk("valid", {31'b0, dec_valid_o}, {31'b0, ev});
        chk("pc",    dec_pc_o, epc);
        chk("instr", dec_instr_o, ev ? (32'hA000_0000 | epc) : 32'h0000_0013);
        chk("pc4",   dec_pc4_o, epc + 32'd4);
        chk("req",   {31'b0, imem_req_o}, {31'b0, req});
        chk("addr",  imem_addr_o, m_pc);
        chk("count", {29'b0, fq_count_o}, sz);
        if (redir) begin
            q_pc.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(q_pc.pop_front());
            if (req) begin
                if (!byp) q_pc.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        dec_ready_i = 1'b0;
        m_pc = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_count", {29'b0, fq_count_o}, 32'd0);
        chk("rst_valid", {31'b0, dec_valid_o}, 32'd0);
        chk("rst_instr", dec_instr_o, 32'h0000_0013);
        chk("rst_pc",    dec_pc_o, 32'h0);
        chk("rst_addr",  imem_addr_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // streaming, then decode stall until full, then drain
        repeat (6) step(1, 0, 0);
        repeat (8) step(0, 0, 0);
        chk("full_count", {29'b0, fq_count_o}, 32'd4);
        repeat (6) step(1, 0, 0);
        // fill, redirect while full
        repeat (8) step(0, 0, 0);
        step(0, 1, 32'h100);
        repeat (4) step(1, 0, 0);
        // misaligned target and back-to-back redirects
        step(1, 1, 32'h103);
        chk("align_addr", imem_addr_o, 32'h100);
        repeat (3) step(1, 0, 0);
        step(1, 1, 32'h200);
        step(1, 1, 32'h300);
        repeat (4) step(1, 0, 0);

        // async reset mid-fill, no clock edge involved
        step(1, 1, 32'h40);
        repeat (3) step(0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_count", {29'b0, fq_count_o}, 32'd0);
        chk("arst_valid", {31'b0, dec_valid_o}, 32'd0);
        chk("arst_instr", dec_instr_o, 32'h0000_0013);
        chk("arst_addr",  imem_addr_o, 32'h0);
        q_pc.delete();
        m_pc = 32'h0;
        #1;
        rst_n = 1'b1;
        repeat (4) step(1, 0, 0);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
